tag_match_cache: RTL and testbench

- Parametrised, sequential successor to the team's single-tag combinational match predicate.
- Holds DEPTH stored tags with valid bits and supports tag allocation with round-robin replacement.
- Answers lookup requests through a registered valid/ready result stage, giving hit and entry index.
- Sits between the tag-producing front end and the consumer logic as a small fully-associative match table.

---
 rtl/tag_match_cache.sv | 145 ++++++++++++++
 tb/tb_tag_match_cache.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tag_match_cache.sv
// tag_match_cache: small fully-associative tag table with allocate/dedupe,
// round-robin replacement when full, and a registered valid/ready lookup result.

// Per-entry comparator: one instance per stored tag, checked against both
// the lookup tag and the allocation tag in the same cycle.
module tag_match_entry #(
   parameter int TAG_W = 8
) (
   input  logic             vld,
   input  logic [TAG_W-1:0] tag,
   input  logic [TAG_W-1:0] lookup_tag,
   input  logic [TAG_W-1:0] alloc_tag,
   output logic             lk_hit,
   output logic             al_hit
);
   assign lk_hit = vld && (tag == lookup_tag);
   assign al_hit = vld && (tag == alloc_tag);
endmodule

module tag_match_cache #(
   parameter int TAG_W = 8,
   parameter int DEPTH = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic             lookup_valid,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [IDX_W-1:0] res_idx,
   output logic [IDX_W:0]   occupancy
);
   localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

   logic [DEPTH-1:0][TAG_W-1:0] tags_q, tags_d;
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [IDX_W-1:0]            victim_q, victim_d;
   logic [IDX_W:0]              occ_q, occ_d;
   logic                        res_valid_q, res_valid_d;
   logic                        res_hit_q, res_hit_d;
   logic [IDX_W-1:0]            res_idx_q, res_idx_d;

   logic [DEPTH-1:0] lk_match, al_match;
   logic [IDX_W-1:0] lk_idx, free_idx;
   logic             lk_accept;

   // All matching is against the pre-edge table, so a same-cycle alloc or
   // flush never influences the lookup result.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      tag_match_entry #(.TAG_W(TAG_W)) u_ent (
         .vld       (valid_q[g]),
         .tag       (tags_q[g]),
         .lookup_tag(lookup_tag),
         .alloc_tag (alloc_tag),
         .lk_hit    (lk_match[g]),
         .al_hit    (al_match[g])
      );
   end

   // Lowest-index encoders: first matching entry and first free slot.
   always_comb begin
      lk_idx   = '0;
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (lk_match[i]) lk_idx = IDX_W'(i);
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   // Table update: flush wins over alloc; alloc dedupes, fills the lowest
   // hole, or replaces the victim and advances it when full.
   always_comb begin
      tags_d   = tags_q;
      valid_d  = valid_q;
      victim_d = victim_q;
      occ_d    = occ_q;
      if (flush) begin
         valid_d  = '0;
         victim_d = '0;
         occ_d    = '0;
      end else if (alloc_valid && !(|al_match)) begin
         if (occ_q != FULL) begin
            tags_d[free_idx]  = alloc_tag;
            valid_d[free_idx] = 1'b1;
            occ_d             = occ_q + (IDX_W+1)'(1);
         end else begin
            tags_d[victim_q] = alloc_tag;
            victim_d         = victim_q + IDX_W'(1);
         end
      end
   end

   // Result stage: load on accept, drop valid after a handshake with no
   // replacement, otherwise hold steady under backpressure.
   assign lookup_ready = !res_valid_q || res_ready;
   assign lk_accept    = lookup_valid && lookup_ready;

   always_comb begin
      res_valid_d = res_valid_q;
      res_hit_d   = res_hit_q;
      res_idx_d   = res_idx_q;
      if (lk_accept) begin
         res_valid_d = 1'b1;
         res_hit_d   = |lk_match;
         res_idx_d   = lk_idx;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // Control state with synchronous reset; reset also discards a pending result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= '0;
         victim_q    <= '0;
         occ_q       <= '0;
         res_valid_q <= 1'b0;
         res_hit_q   <= 1'b0;
         res_idx_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         victim_q    <= victim_d;
         occ_q       <= occ_d;
         res_valid_q <= res_valid_d;
         res_hit_q   <= res_hit_d;
         res_idx_q   <= res_idx_d;
      end
   end

   // Tag storage needs no reset: entries are qualified by their valid bits.
   always_ff @(posedge clk) begin
      tags_q <= tags_d;
   end

   assign res_valid = res_valid_q;
   assign res_hit   = res_hit_q;
   assign res_idx   = res_idx_q;
   assign occupancy = occ_q;
endmodule

// File: tb/tb_tag_match_cache.sv
// Bench for tag_match_cache: reference model plus result scoreboard, with
// explicit spot checks on the key scenarios.
module tb_tag_match_cache;
   localparam int TAG_W = 8;
   localparam int DEPTH = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             alloc_valid = 1'b0;
   logic [TAG_W-1:0] alloc_tag = '0;
   logic             lookup_valid = 1'b0;
   logic [TAG_W-1:0] lookup_tag = '0;
   logic             lookup_ready;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic             res_hit;
   logic [IDX_W-1:0] res_idx;
   logic [IDX_W:0]   occupancy;

   tag_match_cache #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
      .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_ready(lookup_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } res_t;

   int   n_chk = 0;
   int   n_err = 0;
   res_t sb_q[$];

   // Reference model state (state after the most recent edge)
   logic [TAG_W-1:0] m_tag[DEPTH];
   logic [DEPTH-1:0] m_val = '0;
   int               m_vic = 0;
   int               m_occ = 0;
   logic             m_rv = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_find(input logic [TAG_W-1:0] t);
      for (int i = 0; i < DEPTH; i++)
         if (m_val[i] && m_tag[i] == t) return i;
      return -1;
   endfunction

   // One clock: check at negedge against the model, advance the model to the
   // post-edge state, then return 1 time unit after the rising edge.
   task automatic cycle();
      int   li, ai;
      logic acc;
      @(negedge clk);
      if (!rst_n) begin
         m_val = '0; m_vic = 0; m_occ = 0; m_rv = 1'b0;
         sb_q.delete();
      end else begin
         chk("occupancy", 32'(occupancy), 32'(m_occ));
         chk("res_valid", 32'(res_valid), 32'(m_rv));
         chk("lookup_ready", 32'(lookup_ready), 32'(!m_rv || res_ready));
         if (m_rv) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else begin
               chk("res_hit", 32'(res_hit), 32'(sb_q[0].hit));
               chk("res_idx", 32'(res_idx), 32'(sb_q[0].idx));
               if (res_ready) void'(sb_q.pop_front());
            end
         end
         acc = lookup_valid && (!m_rv || res_ready);
         if (acc) begin
            li = m_find(lookup_tag);
            sb_q.push_back(res_t'{hit: (li >= 0), idx: (li >= 0) ? IDX_W'(li) : '0});
         end
         m_rv = acc ? 1'b1 : (res_ready ? 1'b0 : m_rv);
         if (flush) begin
            m_val = '0; m_vic = 0; m_occ = 0;
         end else if (alloc_valid && m_find(alloc_tag) < 0) begin
            if (m_occ < DEPTH) begin
               ai = 0;
               while (m_val[ai]) ai++;
               m_tag[ai] = alloc_tag; m_val[ai] = 1'b1; m_occ++;
            end else begin
               m_tag[m_vic] = alloc_tag;
               m_vic = (m_vic + 1) % DEPTH;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [TAG_W-1:0] t);
      alloc_valid = 1'b1; alloc_tag = t;
      cycle();
      alloc_valid = 1'b0;
   endtask

   task automatic lookup(input logic [TAG_W-1:0] t);
      lookup_valid = 1'b1; lookup_tag = t;
      cycle();
      lookup_valid = 1'b0;
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      cycle(); cycle();
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_occ", 32'(occupancy), 32'(0));
      chk("rst_res_hit", 32'(res_hit), 32'(0));
      chk("rst_res_idx", 32'(res_idx), 32'(0));
      rst_n = 1'b1;
      cycle();

      // Lookup into empty table
      lookup(8'h00);
      chk("empty_valid", 32'(res_valid), 32'(1));
      chk("empty_hit", 32'(res_hit), 32'(0));
      chk("empty_idx", 32'(res_idx), 32'(0));
      chk("empty_rdy", 32'(lookup_ready), 32'(1));

      // Allocate, lookup, dedupe
      alloc(8'h11); alloc(8'h22); alloc(8'h33);
      lookup(8'h22);
      chk("lk22_hit", 32'(res_hit), 32'(1));
      chk("lk22_idx", 32'(res_idx), 32'(1));
      chk("occ3", 32'(occupancy), 32'(3));
      alloc(8'h22);
      chk("dedupe_occ", 32'(occupancy), 32'(3));

      // Fill, then round-robin replacement
      alloc(8'h44);
      chk("occ_full", 32'(occupancy), 32'(4));
      alloc(8'h55); alloc(8'h66);
      chk("occ_repl", 32'(occupancy), 32'(4));
      lookup(8'h11);
      chk("lk11_miss", 32'(res_hit), 32'(0));
      lookup(8'h66);
      chk("lk66_hit", 32'(res_hit), 32'(1));
      chk("lk66_idx", 32'(res_idx), 32'(1));
      lookup(8'h55);
      chk("lk55_idx", 32'(res_idx), 32'(0));
      lookup(8'h33);
      chk("lk33_idx", 32'(res_idx), 32'(2));
      // Victim is now 2: next replacement lands in entry 2
      alloc(8'h67);
      lookup(8'h67);
      chk("vic2_idx", 32'(res_idx), 32'(2));

      // Same-cycle alloc + lookup sees pre-write table
      flush = 1'b1; cycle(); flush = 1'b0;
      alloc_valid = 1'b1; alloc_tag = 8'h77;
      lookup(8'h77);
      alloc_valid = 1'b0;
      chk("same_cyc_miss", 32'(res_hit), 32'(0));
      lookup(8'h77);
      chk("next_cyc_hit", 32'(res_hit), 32'(1));
      chk("next_cyc_idx", 32'(res_idx), 32'(0));
      cycle();

      // Backpressure with held hit at idx 2
      alloc(8'h88); alloc(8'h99);
      res_ready = 1'b0;
      lookup(8'h99);
      lookup_valid = 1'b1; lookup_tag = 8'h77;
      for (int k = 0; k < 3; k++) begin
         chk("bp_rdy", 32'(lookup_ready), 32'(0));
         chk("bp_idx", 32'(res_idx), 32'(2));
         chk("bp_hit", 32'(res_hit), 32'(1));
         cycle();
      end
      res_ready = 1'b1;
      cycle();
      lookup_valid = 1'b0;
      chk("bp_new_idx", 32'(res_idx), 32'(0));
      chk("bp_new_hit", 32'(res_hit), 32'(1));
      cycle();

      // Flush + alloc on full table with a held result
      alloc(8'haa);
      chk("full_again", 32'(occupancy), 32'(4));
      res_ready = 1'b0;
      lookup(8'h88);
      flush = 1'b1; alloc_valid = 1'b1; alloc_tag = 8'h99;
      cycle();
      flush = 1'b0; alloc_valid = 1'b0;
      chk("flush_occ", 32'(occupancy), 32'(0));
      chk("flush_held_v", 32'(res_valid), 32'(1));
      chk("flush_held_idx", 32'(res_idx), 32'(1));
      res_ready = 1'b1;
      lookup(8'h99);
      chk("flush_99_miss", 32'(res_hit), 32'(0));

      // Reset while a result awaits handshake
      res_ready = 1'b0;
      lookup(8'h12);
      chk("pre_rst_valid", 32'(res_valid), 32'(1));
      rst_n = 1'b0;
      cycle();
      chk("mid_rst_valid", 32'(res_valid), 32'(0));
      rst_n = 1'b1; res_ready = 1'b1;

      // Random traffic against the model
      for (int k = 0; k < 200; k++) begin
         alloc_valid  = ($urandom_range(0, 2) == 0);
         alloc_tag    = 8'($urandom_range(0, 7));
         lookup_valid = ($urandom_range(0, 1) == 0);
         lookup_tag   = 8'($urandom_range(0, 7));
         res_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 30) == 0);
         cycle();
      end
      alloc_valid = 1'b0; lookup_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
      cycle(); cycle();
      chk("sb_drained", 32'(sb_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
